// File: rtl/intra_reconstructor_if.sv
// ---------------------------------------------------------------------------
// intra_reconstructor_if
// Bundles the macroblock request side (start, mode, mbnumber, residues, top,
// left, availability flags) and the pixel stream side (pix_* handshake,
// busy, done) of the intra reconstructor.
//   master : the residue/mode store and pixel sink (drives requests, ready)
//   slave  : the reconstructor (drives busy, pixel stream, done)
// residues element k = row*MB_SIZE_L + col, each a signed 8-bit value.
// ---------------------------------------------------------------------------
interface intra_reconstructor_if #(
  parameter int MB_SIZE_L = 8,
  parameter int MB_SIZE_W = 8
);
  logic                                     start;
  logic [2:0]                               mode;
  logic [12:0]                              mbnumber;
  logic [MB_SIZE_L*MB_SIZE_W-1:0][7:0]      residues;
  logic [MB_SIZE_L-1:0][7:0]                top;
  logic [MB_SIZE_W-1:0][7:0]                left;
  logic                                     top_avail;
  logic                                     left_avail;
  logic                                     pix_ready;
  logic                                     busy;
  logic                                     pix_valid;
  logic [7:0]                               pix_data;
  logic [19:0]                              pix_addr;
  logic                                     pix_last;
  logic                                     done;

  modport master (
    output start, mode, mbnumber, residues, top, left, top_avail, left_avail,
           pix_ready,
    input  busy, pix_valid, pix_data, pix_addr, pix_last, done
  );

  modport slave (
    input  start, mode, mbnumber, residues, top, left, top_avail, left_avail,
           pix_ready,
    output busy, pix_valid, pix_data, pix_addr, pix_last, done
  );
endinterface

// File: rtl/intra_reconstructor.sv
// ---------------------------------------------------------------------------
// intra_reconstructor
// Rebuilds an intra-predicted macroblock (vertical / horizontal / DC) and
// streams clip(pred + residue) pixels in raster order with frame addresses.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : intra_reconstructor_if.slave (request in, pixel stream out)
// Flow: IDLE -(start)-> SUM (max(L,W) cycles, neighbour sums) -> EMIT
//       (one pixel per handshake) -> DONE (one-cycle done pulse) -> IDLE
// ---------------------------------------------------------------------------
module intra_reconstructor #(
  parameter int WIDTH     = 720,
  parameter int LENGTH    = 1280,
  parameter int MB_SIZE_L = 8,
  parameter int MB_SIZE_W = 8
) (
  input logic                  clk,
  input logic                  reset,
  intra_reconstructor_if.slave bus
);

  localparam int L    = MB_SIZE_L;
  localparam int W    = MB_SIZE_W;
  localparam int N    = (L > W) ? L : W;
  localparam int CW   = $clog2(N);
  localparam int JW   = $clog2(L);
  localparam int IW   = $clog2(W);
  localparam int NPIX = L * W;
  localparam int LW   = L + W;
  localparam int MBPR = LENGTH / L;

  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [JW-1:0] J_LAST   = JW'(L - 1);
  localparam logic [IW-1:0] I_LAST   = IW'(W - 1);

  if (!((L == 4 || L == 8 || L == 16) && (W == 4 || W == 8 || W == 16)) ||
      (WIDTH % W) != 0) begin : g_bad_geometry
    $error("intra_reconstructor: unsupported macroblock geometry");
  end

  typedef enum logic [1:0] {S_IDLE, S_SUM, S_EMIT, S_DONE} state_t;

  state_t                r_state, w_next;
  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_i, w_ni;
  logic [JW-1:0]         r_j, w_nj;
  logic [12:0]           r_sum_t, r_sum_l, w_sum_t_fin, w_sum_l_fin;
  logic [7:0]            r_dc, w_dc, w_dc_cur;
  logic [7:0]            w_t_term, w_l_term;

  logic [2:0]            r_mode;
  logic [12:0]           r_mbnum;
  logic [NPIX-1:0][7:0]  r_res;
  logic [L-1:0][7:0]     r_top;
  logic [W-1:0][7:0]     r_left;
  logic                  r_tav, r_lav;

  logic                  r_busy, r_pix_valid, r_pix_last, r_done;
  logic [7:0]            r_pix_data;
  logic [19:0]           r_pix_addr;

  logic                  w_hs, w_last;
  logic [7:0]            w_pred, w_res, w_pix;
  logic signed [9:0]     w_recon;
  logic [31:0]           w_mb_x, w_mb_y;
  logic [19:0]           w_addr;

  function automatic logic [7:0] sat_u8(input logic signed [9:0] x);
    if (x < 0)             return 8'd0;
    else if (x > 10'sd255) return 8'hFF;
    else                   return x[7:0];
  endfunction

  // Rounded DC mean; for power-of-two divisors the divide folds into a shift.
  function automatic logic [7:0] dc_value(input logic [12:0] st,
                                          input logic [12:0] sl,
                                          input logic tav, input logic lav);
    logic [14:0] acc;
    if (tav && lav) begin
      acc = 15'(st) + 15'(sl) + 15'(LW / 2);
      return 8'(acc / 15'(LW));
    end else if (tav) begin
      acc = 15'(st) + 15'(L / 2);
      return 8'(acc >> JW);
    end else if (lav) begin
      acc = 15'(sl) + 15'(W / 2);
      return 8'(acc >> IW);
    end else begin
      return 8'd128;
    end
  endfunction

  assign w_hs = r_pix_valid & bus.pix_ready;

  // ---- FSM: state register / next state ----
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start) w_next = S_SUM;
      S_SUM:   if (r_cnt == CNT_LAST) w_next = S_EMIT;
      S_EMIT:  if (w_hs && r_pix_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ---- SUM stage: neighbour term selected by the counter ----
  always_comb begin
    w_t_term = '0;
    w_l_term = '0;
    for (int k = 0; k < L; k++) if (r_cnt == CW'(k)) w_t_term = r_top[k];
    for (int k = 0; k < W; k++) if (r_cnt == CW'(k)) w_l_term = r_left[k];
  end

  assign w_sum_t_fin = r_sum_t + 13'(w_t_term);
  assign w_sum_l_fin = r_sum_l + 13'(w_l_term);
  assign w_dc        = dc_value(w_sum_t_fin, w_sum_l_fin, r_tav, r_lav);
  // The first pixel is formed on the same edge that captures the DC value.
  assign w_dc_cur    = (r_state == S_SUM) ? w_dc : r_dc;

  // ---- EMIT stage: index of the pixel to present next ----
  always_comb begin
    w_ni = r_i;
    w_nj = r_j;
    if (r_state == S_SUM) begin
      w_ni = '0;
      w_nj = '0;
    end else if (r_j == J_LAST) begin
      w_ni = r_i + 1'b1;
      w_nj = '0;
    end else begin
      w_nj = r_j + 1'b1;
    end
  end

  always_comb begin
    w_pred = w_dc_cur;
    case (r_mode)
      3'd0:    w_pred = r_tav ? r_top[w_nj]  : 8'd128;
      3'd1:    w_pred = r_lav ? r_left[w_ni] : 8'd128;
      default: w_pred = w_dc_cur;
    endcase
  end

  // L is a power of two, so row*L + col is the concatenation {row, col}.
  assign w_res   = r_res[{w_ni, w_nj}];
  assign w_recon = $signed({2'b00, w_pred}) + $signed({{2{w_res[7]}}, w_res});
  assign w_pix   = sat_u8(w_recon);
  assign w_last  = (w_ni == I_LAST) && (w_nj == J_LAST);

  assign w_mb_x = 32'(r_mbnum) % 32'(MBPR);
  assign w_mb_y = 32'(r_mbnum) / 32'(MBPR);
  assign w_addr = 20'((w_mb_y * 32'(W) + 32'(w_ni)) * 32'(LENGTH) +
                      w_mb_x * 32'(L) + 32'(w_nj));

  // ---- Request capture (accept cycle only) ----
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && bus.start) begin
      r_mode  <= bus.mode;
      r_mbnum <= bus.mbnumber;
      r_res   <= bus.residues;
      r_top   <= bus.top;
      r_left  <= bus.left;
      r_tav   <= bus.top_avail;
      r_lav   <= bus.left_avail;
    end
  end

  // ---- Counters, sums and registered outputs ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_sum_t     <= '0;
      r_sum_l     <= '0;
      r_dc        <= '0;
      r_busy      <= 1'b0;
      r_pix_valid <= 1'b0;
      r_pix_data  <= '0;
      r_pix_addr  <= '0;
      r_pix_last  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_sum_t <= '0;
            r_sum_l <= '0;
          end
        end
        S_SUM: begin
          r_sum_t <= w_sum_t_fin;
          r_sum_l <= w_sum_l_fin;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_dc        <= w_dc;
            r_i         <= w_ni;
            r_j         <= w_nj;
            r_pix_valid <= 1'b1;
            r_pix_data  <= w_pix;
            r_pix_addr  <= w_addr;
            r_pix_last  <= w_last;
          end
        end
        S_EMIT: begin
          if (w_hs) begin
            if (r_pix_last) begin
              r_pix_valid <= 1'b0;
              r_pix_last  <= 1'b0;
              r_pix_data  <= '0;
              r_pix_addr  <= '0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
            end else begin
              r_i        <= w_ni;
              r_j        <= w_nj;
              r_pix_data <= w_pix;
              r_pix_addr <= w_addr;
              r_pix_last <= w_last;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.pix_valid = r_pix_valid;
  assign bus.pix_data  = r_pix_data;
  assign bus.pix_addr  = r_pix_addr;
  assign bus.pix_last  = r_pix_last;
  assign bus.done      = r_done;

endmodule
